endstop_event_fifo: RTL and testbench

ENDSTOP_EVENT_FIFO -- requirements
Module: endstop_event_fifo

---
 rtl/endstop_event_fifo_pkg.sv | 27 ++
 rtl/endstop_fifo_mem.sv | 39 +++
 rtl/endstop_event_fifo.sv | 187 ++++++++++++++++++
 tb/tb_endstop_event_fifo.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/endstop_event_fifo_pkg.sv
// Shared types for the endstop event FIFO: capture FSM states and the
// stored event record. Build option: ENDSTOP_EVENT_TIMESTAMP_EN adds ts.
package endstop_event_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        UNLOCK,
        WAIT_CLR
    } ev_state_e;

    // Position/bounce fields are held at this width in storage.
    localparam int EV_POS_W = 32;

    typedef struct packed {
        logic                level;
        logic [EV_POS_W-1:0] pos;
        logic [EV_POS_W-1:0] bounce;
        logic [7:0]          cycles;
`ifdef ENDSTOP_EVENT_TIMESTAMP_EN
        logic [31:0]         ts;
`endif
    } ev_entry_t;

    localparam int EV_ENTRY_W = $bits(ev_entry_t);

endpackage

// File: rtl/endstop_fifo_mem.sv
// Event storage: DEPTH x W array, one write port, one registered read port.
// Ports: clk, rst_n, we_i/waddr_i/wdata_i (write), raddr_i -> rdata_o.
module endstop_fifo_mem #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [W-1:0]             wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [W-1:0]             rdata_o
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Bypass covers a write landing on the slot that becomes the head
    // in the same cycle (write into empty, or write+pop at count 1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (we_i && (waddr_i == raddr_i)) begin
            rdata_q <= wdata_i;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/endstop_event_fifo.sv
// Captures debouncer endstop events into a FIFO and re-arms the debouncer.
// Ports: clk, reset (async low), debouncer in (signal_changed, signal,
// pos_out, max_bounce, cycles), unlock out, flush/clear_overflow pulses,
// read side rd_ready/rd_valid/rd_*, status count/overflow/drop_count.
// Build option ENDSTOP_EVENT_TIMESTAMP_EN adds rd_timestamp.
module endstop_event_fifo
    import endstop_event_fifo_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int POS_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     signal_changed,
    input  logic                     signal,
    input  logic [POS_W-1:0]         pos_out,
    input  logic [POS_W-1:0]         max_bounce,
    input  logic [7:0]               cycles,
    output logic                     unlock,
    input  logic                     flush,
    input  logic                     clear_overflow,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [POS_W-1:0]         rd_pos,
    output logic [POS_W-1:0]         rd_bounce,
    output logic [7:0]               rd_cycles,
    output logic                     rd_level,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [7:0]               drop_count
`ifdef ENDSTOP_EVENT_TIMESTAMP_EN
    ,
    output logic [31:0]              rd_timestamp
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    ev_state_e        state_q;
    logic             unlock_q;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       drop_q, drop_d;
    logic             cap, full, pop, wr_en, drop;
    ev_entry_t        wr_entry;
    ev_entry_t        rd_entry;

    // Capture FSM; unlock is registered so it coincides with UNLOCK.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            unlock_q <= 1'b0;
        end else begin
            unlock_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (signal_changed) state_q <= CAPTURE;
                end
                CAPTURE: begin
                    state_q  <= UNLOCK;
                    unlock_q <= 1'b1;
                end
                UNLOCK: begin
                    state_q <= WAIT_CLR;
                end
                WAIT_CLR: begin
                    if (!signal_changed) state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef ENDSTOP_EVENT_TIMESTAMP_EN
    logic [31:0] ts_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 32'd1;
        end
    end
`endif

    always_comb begin
        wr_entry        = '0;
        wr_entry.level  = signal;
        wr_entry.pos    = EV_POS_W'(pos_out);
        wr_entry.bounce = EV_POS_W'(max_bounce);
        wr_entry.cycles = cycles;
`ifdef ENDSTOP_EVENT_TIMESTAMP_EN
        wr_entry.ts     = ts_q;
`endif
    end

    // A pop in the capture cycle frees the slot, so a full FIFO
    // only drops when nothing is leaving. Flush discards everything.
    always_comb begin
        cap   = (state_q == CAPTURE);
        full  = (cnt_q == FULL_CNT);
        pop   = (cnt_q != '0) && rd_ready;
        wr_en = cap && (!full || pop) && !flush;
        drop  = cap && full && !pop && !flush;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (wr_en && !pop) cnt_d = cnt_q + CNT_W'(1);
            if (!wr_en && pop) cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // A drop in the same cycle as a clear restarts the tally at one.
    always_comb begin
        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (drop) begin
            ovf_d = 1'b1;
            if (clear_overflow) begin
                drop_d = 8'd1;
            end else if (drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
        end else if (clear_overflow) begin
            ovf_d  = 1'b0;
            drop_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end

    // Read address is the next head so the registered output tracks it.
    endstop_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (EV_ENTRY_W)
    ) u_mem (
        .clk     (clk),
        .rst_n   (reset),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_d),
        .rdata_o (rd_entry)
    );

    assign unlock     = unlock_q;
    assign rd_valid   = (cnt_q != '0);
    assign rd_pos     = POS_W'(rd_entry.pos);
    assign rd_bounce  = POS_W'(rd_entry.bounce);
    assign rd_cycles  = rd_entry.cycles;
    assign rd_level   = rd_entry.level;
    assign count      = cnt_q;
    assign overflow   = ovf_q;
    assign drop_count = drop_q;
`ifdef ENDSTOP_EVENT_TIMESTAMP_EN
    assign rd_timestamp = rd_entry.ts;
`endif

endmodule

// File: tb/tb_endstop_event_fifo.sv
// Scoreboard bench for endstop_event_fifo (DEPTH=4, POS_W=32).
// Expected entries are queued at stimulus time; a monitor checks pops.
module tb_endstop_event_fifo;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        signal_changed = 1'b0;
    logic        sig = 1'b0;
    logic [31:0] pos_out = '0;
    logic [31:0] max_bounce = '0;
    logic [7:0]  cycles = '0;
    logic        unlock;
    logic        flush = 1'b0;
    logic        clear_overflow = 1'b0;
    logic        rd_ready = 1'b0;
    logic        rd_valid;
    logic [31:0] rd_pos;
    logic [31:0] rd_bounce;
    logic [7:0]  rd_cycles;
    logic        rd_level;
    logic [2:0]  count;
    logic        overflow;
    logic [7:0]  drop_count;
`ifdef ENDSTOP_EVENT_TIMESTAMP_EN
    logic [31:0] rd_timestamp;
`endif

    endstop_event_fifo #(.DEPTH(4), .POS_W(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .signal_changed (signal_changed),
        .signal         (sig),
        .pos_out        (pos_out),
        .max_bounce     (max_bounce),
        .cycles         (cycles),
        .unlock         (unlock),
        .flush          (flush),
        .clear_overflow (clear_overflow),
        .rd_ready       (rd_ready),
        .rd_valid       (rd_valid),
        .rd_pos         (rd_pos),
        .rd_bounce      (rd_bounce),
        .rd_cycles      (rd_cycles),
        .rd_level       (rd_level),
        .count          (count),
        .overflow       (overflow),
        .drop_count     (drop_count)
`ifdef ENDSTOP_EVENT_TIMESTAMP_EN
        ,
        .rd_timestamp   (rd_timestamp)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pos;
        logic [31:0] bnc;
        logic [7:0]  cyc;
        logic        lvl;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   tests = 0;
    int   fails = 0;
    int   unlock_cnt = 0;
    int   u0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (reset && unlock) unlock_cnt++;
    end

    always @(negedge clk) begin
        if (reset && rd_valid && rd_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected: got pos %0h expected none",
                         rd_pos);
            end else begin
                e = exp_q.pop_front();
                if (rd_pos !== e.pos || rd_bounce !== e.bnc ||
                    rd_cycles !== e.cyc || rd_level !== e.lvl) begin
                    fails++;
                    $display("FAIL sb_entry: got %0h/%0h/%0h/%0b expected %0h/%0h/%0h/%0b",
                             rd_pos, rd_bounce, rd_cycles, rd_level,
                             e.pos, e.bnc, e.cyc, e.lvl);
                end
            end
        end
    end

    task automatic fire(input logic [31:0] p, input logic [31:0] b,
                        input logic [7:0] c, input logic l,
                        input bit stored, input bit popcap,
                        input bit flushcap, input bit clrcap,
                        input int hold);
        @(posedge clk); #1;
        signal_changed = 1'b1;
        sig = l; pos_out = p; max_bounce = b; cycles = c;
        if (stored) exp_q.push_back('{p, b, c, l});
        @(posedge clk); #1;
        if (popcap) rd_ready = 1'b1;
        if (flushcap) begin
            flush = 1'b1;
            exp_q.delete();
        end
        if (clrcap) clear_overflow = 1'b1;
        @(negedge clk);
        chk("unlock_in_capture", 32'(unlock), 0);
        @(posedge clk); #1;
        rd_ready = 1'b0; flush = 1'b0; clear_overflow = 1'b0;
        @(negedge clk);
        chk("unlock_pulse", 32'(unlock), 1);
        chk("rd_valid_after_cap", 32'(rd_valid), 32'(exp_q.size() != 0));
        chk("count_after_cap", 32'(count), exp_q.size());
        repeat (hold) @(negedge clk);
        signal_changed = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        rd_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        rd_ready = 1'b0;
        chk("drain_count", 32'(count), 0);
        chk("drain_sb_left", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_unlock", 32'(unlock), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_drop", 32'(drop_count), 0);
        chk("rst_rd_pos", rd_pos, 0);
        chk("rst_rd_fields",
            32'({rd_bounce != 0, rd_cycles != 0, rd_level}), 0);
        reset = 1'b1;

        // single event
        fire(32'h1234, 32'h7, 8'd3, 1'b1, 1, 0, 0, 0, 0);
        chk("single_rd_valid", 32'(rd_valid), 1);
        chk("single_rd_pos", rd_pos, 32'h1234);
        chk("single_rd_level", 32'(rd_level), 1);
        chk("single_count", 32'(count), 1);
        drain();

        // overflow: five events, no reads
        u0 = unlock_cnt;
        fire(32'h100, 32'h1, 8'd1, 1'b1, 1, 0, 0, 0, 0);
        fire(32'h200, 32'h2, 8'd2, 1'b0, 1, 0, 0, 0, 0);
        fire(32'h300, 32'h3, 8'd3, 1'b1, 1, 0, 0, 0, 0);
        fire(32'h400, 32'h4, 8'd4, 1'b0, 1, 0, 0, 0, 0);
        fire(32'h500, 32'h5, 8'd5, 1'b1, 0, 0, 0, 0, 0);
        chk("ovf_count", 32'(count), 4);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_drops", 32'(drop_count), 1);
        chk("ovf_unlocks", unlock_cnt - u0, 5);

        // full with pop in capture cycle: no drop
        fire(32'h600, 32'h6, 8'd6, 1'b0, 1, 1, 0, 0, 0);
        chk("fullpop_count", 32'(count), 4);
        chk("fullpop_drops", 32'(drop_count), 1);

        // clear coinciding with a drop
        fire(32'h700, 32'h7, 8'd7, 1'b1, 0, 0, 0, 1, 0);
        chk("clrdrop_flag", 32'(overflow), 1);
        chk("clrdrop_drops", 32'(drop_count), 1);
        @(posedge clk); #1;
        clear_overflow = 1'b1;
        @(posedge clk); #1;
        clear_overflow = 1'b0;
        chk("clr_flag", 32'(overflow), 0);
        chk("clr_drops", 32'(drop_count), 0);
        drain();

        // flag held high after unlock
        u0 = unlock_cnt;
        fire(32'h800, 32'h8, 8'd8, 1'b1, 1, 0, 0, 0, 10);
        chk("hold_count", 32'(count), 1);
        chk("hold_unlocks", unlock_cnt - u0, 1);
        drain();

        // flush in capture cycle
        fire(32'h900, 32'h9, 8'd9, 1'b0, 1, 0, 0, 0, 0);
        fire(32'hA00, 32'hA, 8'd10, 1'b1, 0, 0, 1, 0, 0);
        chk("flush_count", 32'(count), 0);
        chk("flush_rd_valid", 32'(rd_valid), 0);
        fire(32'hB00, 32'hB, 8'd11, 1'b1, 1, 0, 0, 0, 0);
        drain();

        // reset during UNLOCK, then release with flag still high
        @(posedge clk); #1;
        signal_changed = 1'b1;
        sig = 1'b1; pos_out = 32'hC00; max_bounce = 32'hC; cycles = 8'd12;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("rstmid_unlock", 32'(unlock), 0);
        chk("rstmid_count", 32'(count), 0);
        chk("rstmid_rd_valid", 32'(rd_valid), 0);
        sig = 1'b0; pos_out = 32'hD00; max_bounce = 32'hD; cycles = 8'd13;
        exp_q.push_back('{32'hD00, 32'hD, 8'd13, 1'b0});
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstrel_unlock", 32'(unlock), 1);
        chk("rstrel_count", 32'(count), 1);
        signal_changed = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
